clint_timer: RTL

- Memory-mapped machine timer (mtime/mtimecmp). It is the source end of the core's active-low timer interrupt line `ti`.
- It sits on the data-bus peripheral segment. Its `ti` output drives the CSR block's `ti` input directly, with no inversion or synchronizer, because both blocks share the same clock.
- Software programs the compare value and prescaler, and reads the free-running 64-bit time through 32-bit bus accesses.

---
 rtl/clint_timer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/clint_timer.sv
// clint_timer: memory-mapped machine timer (mtime / mtimecmp) with prescaler.
//   clk, rst_n          : clock, asynchronous active-low reset
//   bus_en_n, bus_we_n  : active-low access strobe and write select
//   bus_addr[4:2]       : register select (0 MTIME_LO, 1 MTIME_HI, 2 MTIMECMP_LO,
//                         3 MTIMECMP_HI, 4 CTRL, 5..7 unmapped)
//   bus_wdata           : write data
//   bus_rdata/rvalid    : registered read data, valid one cycle after the strobe
//   ti                  : active-low timer interrupt, registered
module clint_timer #(
  parameter int unsigned PRESC_W      = 8,
  parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_en_n,
  input  logic        bus_we_n,
  input  logic [4:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_rvalid,
  output logic        ti
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DIV_LSB = 8;

  localparam logic [2:0] REG_MTIME_LO = 3'd0;
  localparam logic [2:0] REG_MTIME_HI = 3'd1;
  localparam logic [2:0] REG_CMP_LO   = 3'd2;
  localparam logic [2:0] REG_CMP_HI   = 3'd3;
  localparam logic [2:0] REG_CTRL     = 3'd4;

  logic [63:0]        mtime_q, mtime_d;
  logic [63:0]        mtimecmp_q, mtimecmp_d;
  logic [DATA_W-1:0]  shadow_q, shadow_d;
  logic               en_q, en_d;
  logic [PRESC_W-1:0] div_q, div_d;
  logic [PRESC_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               rvalid_q, rvalid_d;
  logic               ti_q, ti_d;

  logic       rd_c, wr_c, tick_c;
  logic [2:0] sel_c;
  logic       addr_unused;

  // Byte-lane bits of the address carry no meaning for word registers.
  assign addr_unused = ^bus_addr[1:0];

  // Access decode.
  always_comb begin
    sel_c = bus_addr[4:2];
    rd_c  = !bus_en_n && bus_we_n;
    wr_c  = !bus_en_n && !bus_we_n;
  end

  // Prescaler: tick when the count reaches DIV, so one tick every DIV+1 cycles.
  always_comb begin
    tick_c = 1'b0;
    cnt_d  = '0;
    if (en_q) begin
      if (cnt_q == div_q) begin
        tick_c = 1'b1;
      end else begin
        cnt_d = cnt_q + PRESC_W'(1);
      end
    end
    if (wr_c && (sel_c == REG_CTRL)) begin
      cnt_d = '0;
    end
  end

  // Register updates; an mtime write of either half drops that cycle's tick.
  always_comb begin
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    shadow_d   = shadow_q;
    en_d       = en_q;
    div_d      = div_q;

    if (wr_c && (sel_c == REG_MTIME_LO)) begin
      mtime_d[31:0] = bus_wdata;
    end else if (wr_c && (sel_c == REG_MTIME_HI)) begin
      mtime_d[63:32] = bus_wdata;
    end else if (tick_c) begin
      mtime_d = mtime_q + 64'd1;
    end

    // Shadow snapshots the high half on a low read so the pair reads atomically.
    if (rd_c && (sel_c == REG_MTIME_LO)) begin
      shadow_d = mtime_q[63:32];
    end else if (wr_c && (sel_c == REG_MTIME_HI)) begin
      shadow_d = bus_wdata;
    end

    if (wr_c && (sel_c == REG_CMP_LO)) begin
      mtimecmp_d[31:0] = bus_wdata;
    end
    if (wr_c && (sel_c == REG_CMP_HI)) begin
      mtimecmp_d[63:32] = bus_wdata;
    end
    if (wr_c && (sel_c == REG_CTRL)) begin
      en_d  = bus_wdata[0];
      div_d = bus_wdata[DIV_LSB +: PRESC_W];
    end
  end

  // Read path and interrupt; reads use pre-edge register values.
  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = rd_c;
    if (rd_c) begin
      case (sel_c)
        REG_MTIME_LO: rdata_d = mtime_q[31:0];
        REG_MTIME_HI: rdata_d = shadow_q;
        REG_CMP_LO:   rdata_d = mtimecmp_q[31:0];
        REG_CMP_HI:   rdata_d = mtimecmp_q[63:32];
        REG_CTRL:     rdata_d = DATA_W'(en_q) | (DATA_W'(div_q) << DIV_LSB);
        default:      rdata_d = '0;
      endcase
    end
    ti_d = !(mtime_q >= mtimecmp_q);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime_q    <= '0;
      mtimecmp_q <= MTIMECMP_RST;
      shadow_q   <= '0;
      en_q       <= 1'b0;
      div_q      <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      ti_q       <= 1'b1;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      shadow_q   <= shadow_d;
      en_q       <= en_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      ti_q       <= ti_d;
    end
  end

  assign bus_rdata  = rdata_q;
  assign bus_rvalid = rvalid_q;
  assign ti         = ti_q;

endmodule
